// File: rtl/l1b_addr_latch.sv
// Address capture and I/O decode stage: synchronises lat_en, captures cpu_a on a qualified
// rising edge and holds bbc_a plus decode strobes for HOLD_CYCLES. Optional macro: L1B_FE4X_DEC_EN.
module l1b_addr_latch #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic        hsclk,
   input  logic        resetb,
   input  logic        lat_en,
   input  logic [15:0] cpu_a,
   output logic [11:0] bbc_a,
   output logic        dec_rom_reg,
   output logic        dec_shadow_reg,
   output logic        dec_fe4x
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [3:0] CNT_RELOAD = 4'(HOLD_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       pending;
   logic       s1, s2, s3, qual_d;
   logic       qual, rise, capture;
   logic       hit_rom, hit_shadow;

   assign qual       = s2 & s3;
   assign rise       = qual & ~qual_d;
   assign hit_rom    = (cpu_a[15:2] == 14'h3F8C);  // 0xFE30..0xFE33
   assign hit_shadow = (cpu_a[15:2] == 14'h3F8D);  // 0xFE34..0xFE37

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      capture = 1'b0;
      case (state)
         IDLE:    capture = rise;
         HOLD:    capture = (cnt == 4'd0) && (pending || rise);
         default: capture = 1'b0;
      endcase
   end

   // Two-flop synchroniser plus one extra stage so a single-cycle glitch never qualifies.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         qual_d <= 1'b0;
      end else begin
         s1     <= lat_en;
         s2     <= s1;
         s3     <= s2;
         qual_d <= qual;
      end
   end

   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         pending        <= 1'b0;
         bbc_a          <= 12'h000;
         dec_rom_reg    <= 1'b0;
         dec_shadow_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= HOLD;
                  cnt   <= CNT_RELOAD;
               end
            end
            HOLD: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
                  if (rise) pending <= 1'b1;
               end else if (pending || rise) begin
                  pending <= 1'b0;
                  cnt     <= CNT_RELOAD;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (capture) begin
            bbc_a          <= cpu_a[11:0];
            dec_rom_reg    <= hit_rom;
            dec_shadow_reg <= hit_shadow;
         end
      end
   end

`ifdef L1B_FE4X_DEC_EN
   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) dec_fe4x <= 1'b0;
      else if (capture) dec_fe4x <= (cpu_a[15:4] == 12'hFE4);
   end
`else
   assign dec_fe4x = 1'b0;
`endif

endmodule

// File: tb/tb_l1b_addr_latch.sv
// Directed bench for l1b_addr_latch: table-driven captures plus glitch, deferred-capture and
// reset corner sequences. Inputs driven and outputs sampled on the falling edge of hsclk.
module tb_l1b_addr_latch;

   logic        hsclk = 1'b0;
   logic        resetb;
   logic        lat_en;
   logic [15:0] cpu_a;
   logic [11:0] bbc_a;
   logic        dec_rom_reg, dec_shadow_reg, dec_fe4x;

`ifdef L1B_FE4X_DEC_EN
   localparam bit FE4X_ON = 1'b1;
`else
   localparam bit FE4X_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] cpu;
      logic [11:0] bbc;
      logic        rom;
      logic        sh;
      logic        fe;
   } vec_t;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [14:0] last_exp;

   l1b_addr_latch #(.HOLD_CYCLES(4)) dut (
      .hsclk(hsclk), .resetb(resetb), .lat_en(lat_en), .cpu_a(cpu_a),
      .bbc_a(bbc_a), .dec_rom_reg(dec_rom_reg), .dec_shadow_reg(dec_shadow_reg),
      .dec_fe4x(dec_fe4x)
   );

   always #5 hsclk = ~hsclk;

   function automatic logic [14:0] pack(logic [11:0] b, logic r, logic s, logic f);
      return {b, r, s, f};
   endfunction

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] act;
      act = {bbc_a, dec_rom_reg, dec_shadow_reg, dec_fe4x};
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got bbc_a=%h rom/shadow/fe4x=%b required bbc_a=%h rom/shadow/fe4x=%b",
                  name, act[14:3], act[2:0], exp[14:3], exp[2:0]);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge hsclk);
   endtask

   initial begin
      vec_t vecs[15];
      vecs[0]  = '{16'hFE41, 12'hE41, 1'b0, 1'b0, FE4X_ON};
      vecs[1]  = '{16'hFE31, 12'hE31, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{16'hFE35, 12'hE35, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{16'h1234, 12'h234, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{16'hFE30, 12'hE30, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{16'hFE33, 12'hE33, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{16'hFE34, 12'hE34, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{16'hFE37, 12'hE37, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{16'hFE2F, 12'hE2F, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{16'hFE38, 12'hE38, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{16'hFE40, 12'hE40, 1'b0, 1'b0, FE4X_ON};
      vecs[11] = '{16'hFE4F, 12'hE4F, 1'b0, 1'b0, FE4X_ON};
      vecs[12] = '{16'hFE50, 12'hE50, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{16'h0E41, 12'hE41, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{16'hFF31, 12'hF31, 1'b0, 1'b0, 1'b0};

      // Reset with random inputs, then release and stay quiet.
      resetb = 1'b0;
      lat_en = 1'($urandom);
      cpu_a  = 16'($urandom);
      cycles(3);
      last_exp = pack(12'h000, 1'b0, 1'b0, 1'b0);
      check("reset_active", last_exp);
      lat_en = 1'b0;
      resetb = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge hsclk);
         check("reset_quiet", last_exp);
      end

      // Table: raise lat_en before edge k; old value after k+2, new value after k+3.
      foreach (vecs[i]) begin
         cpu_a  = vecs[i].cpu;
         lat_en = 1'b1;
         cycles(3);
         check($sformatf("latency_%h", vecs[i].cpu), last_exp);
         @(negedge hsclk);
         last_exp = pack(vecs[i].bbc, vecs[i].rom, vecs[i].sh, vecs[i].fe);
         check($sformatf("capture_%h", vecs[i].cpu), last_exp);
         lat_en = 1'b0;
         cycles(10);
      end

      // One-cycle glitch must not capture.
      cpu_a  = 16'hFE31;
      lat_en = 1'b1;
      @(negedge hsclk);
      lat_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge hsclk);
         check("glitch", last_exp);
      end

      // Deferred capture: second request arrives while HOLD count is still running.
      cpu_a  = 16'hFE30;
      lat_en = 1'b1;
      cycles(2);
      lat_en = 1'b0;
      @(negedge hsclk);
      lat_en = 1'b1;
      @(negedge hsclk);
      last_exp = pack(12'hE30, 1'b1, 1'b0, 1'b0);
      check("defer_first", last_exp);
      cpu_a = 16'h0ABC;
      for (int i = 0; i < 3; i++) begin
         @(negedge hsclk);
         check($sformatf("defer_hold_%0d", i + 1), last_exp);
      end
      @(negedge hsclk);
      last_exp = pack(12'hABC, 1'b0, 1'b0, 1'b0);
      check("defer_second", last_exp);
      lat_en = 1'b0;
      cycles(12);
      check("defer_settle", last_exp);

      // Reset in the middle of HOLD clears outputs at once; nothing captured afterwards.
      cpu_a  = 16'hFE35;
      lat_en = 1'b1;
      cycles(4);
      last_exp = pack(12'hE35, 1'b0, 1'b1, 1'b0);
      check("midhold_capture", last_exp);
      cycles(2);
      resetb = 1'b0;
      lat_en = 1'b0;
      #1;
      last_exp = pack(12'h000, 1'b0, 1'b0, 1'b0);
      check("midhold_reset", last_exp);
      @(negedge hsclk);
      resetb = 1'b1;
      cycles(10);
      check("midhold_after", last_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
